pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised elastic pipeline register, the successor to the fixed inter-stage registers between IF/ID/EX/MEM/WB. It carries an arbitrary-width payload bundle across one stage boundary with a valid/ready handshake, a 2-entry skid buffer and a synchronous flush. Back-pressure from a downstream hazard stalls the stage without a combinational ready path. Instances sit between every pair of pipeline stages; the payload is the concatenation of that boundary's control and data fields.

## Interface
- DW, 32: payload width in bits, ≥1.
- CLR_ON_FLUSH, 1: 1 = flush also zeroes both data registers; 0 = flush clears only valid state and the data registers hold their values.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all held entries, e.g. on branch mispredict or jump.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; registered.
- in_data  input  DW  upstream payload.
- out_valid  output  1  out_data holds a valid payload; registered.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DW  payload; registered.
- count  output  2  occupancy, 0..2.

## Operation
- Transfer rules:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Storage:
  - main register drives out_data.
  - skid register catches a push that arrives while main is blocked.
- States, encoded as count:
  - EMPTY (0):
    - push: main<=in_data, go to ONE.
    - otherwise: stay.
  - ONE (1):
    - push & pop: main<=in_data, stay.
    - push & !pop: skid<=in_data, go to FULL.
    - pop & !push: go to EMPTY.
    - neither: stay.
  - FULL (2):
    - in_ready=0, so no push is possible.
    - pop: main<=skid, go to ONE.
    - otherwise: stay.
- Decoded outputs: out_valid = (count!=0); in_ready = (count!=2).
- Priority: rst > flush > normal operation.
- Flush:
  - Next state is EMPTY and out_valid=0.
  - A push or pop coincident with flush is discarded; the consumer must ignore that pop.
  - If CLR_ON_FLUSH=1, main and skid are set to 0.
- Reset:
  - count=0, out_valid=0, in_ready=1, out_data=0, skid=0.
  - This applies regardless of CLR_ON_FLUSH.
- Data stability:
  - While out_valid & !out_ready, out_data and out_valid hold.
  - When out_valid=0, out_data holds its last value (0 after reset or after a clearing flush).
- Order: strictly FIFO; payload bits pass through unmodified.

## Timing
- Latency: in_data accepted at edge N appears on out_data after edge N, with out_valid=1 in cycle N+1.
- Throughput: one payload per cycle sustained while out_ready=1.
- Combinational paths:
  - in_ready, out_valid and count depend only on state.
  - No combinational path from out_ready to in_ready or from in_data to out_data.
- Stall: out_ready low for k cycles in ONE with continuous in_valid:
  - First cycle: the stage absorbs one beat into skid.
  - in_ready drops in the next cycle.
  - in_ready returns high one cycle after the first pop.
- Reset or flush asserted mid-stall: takes effect at the next edge, state EMPTY in the following cycle.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, out_data=0; no payload is accepted.
- Streaming:
  - Stimulus: DW=32, out_ready=1, push 0x1..0x8 on consecutive cycles.
  - Required: out_data 0x1..0x8 on 8 consecutive cycles, each one cycle after its push; count stays 1.
- Skid:
  - Stimulus: push 0xA,0xB,0xC back-to-back with out_ready=0 from the second cycle.
  - Required: 0xA and 0xB held, count=2, in_ready=0 and 0xC waits upstream. Raise out_ready -> outputs 0xA,0xB,0xC in order with no loss or duplication.
- Flush in FULL, CLR_ON_FLUSH=1:
  - Stimulus: flush=1 with count=2, in_valid=1 and out_ready=1.
  - Required: next cycle count=0, out_valid=0, out_data=0, in_ready=1; the coincident payload is dropped.
- Flush with CLR_ON_FLUSH=0:
  - Stimulus: main holds 0x55, flush in ONE.
  - Required: out_valid=0 and out_data remains 0x55. A following push of 0x66 appears with out_valid=1.
- Random soak:
  - Stimulus: random in_valid, out_ready and sparse flush for 10k cycles, DW=1 and DW=97.
  - Required: scoreboard confirms FIFO order, no beat lost outside flush, count matches the model, out_data stable during stalls.

Source files
------------

// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for one elastic pipeline boundary: the upstream
// valid/ready/data triple, the downstream triple, the flush request and
// the occupancy readout.  The slave view belongs to the stage itself;
// the master view belongs to whatever surrounds it.
interface pipe_stage_elastic_if #(
    parameter int DW = 32
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer.
// The main register always drives out_data; the skid register only
// catches the one beat that can arrive while main is blocked downstream.
// in_ready and out_valid are registered together with the state, so
// there is no combinational path from out_ready back to in_ready.
module pipe_stage_elastic #(
    parameter int DW           = 32,
    parameter bit CLR_ON_FLUSH = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    pipe_stage_elastic_if.slave bus
);

    // The state value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic [DW-1:0] main_data;
    logic [DW-1:0] skid_data;
    logic          can_accept;
    logic          has_data;
    logic          push;
    logic          pop;

    assign push = bus.in_valid & can_accept;
    assign pop  = has_data & bus.out_ready;

    assign bus.in_ready  = can_accept;
    assign bus.out_valid = has_data;
    assign bus.out_data  = main_data;
    assign bus.count     = state;

    // Occupancy FSM with registered handshake flags; reset beats flush beats normal moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            can_accept <= 1'b1;
            has_data   <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (bus.flush) begin
            state      <= EMPTY;
            can_accept <= 1'b1;
            has_data   <= 1'b0;
            if (CLR_ON_FLUSH) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_data <= bus.in_data;
                        state     <= ONE;
                        has_data  <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data <= bus.in_data;
                    end else if (push) begin
                        skid_data  <= bus.in_data;
                        state      <= FULL;
                        can_accept <= 1'b0;
                    end else if (pop) begin
                        state    <= EMPTY;
                        has_data <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_data  <= skid_data;
                        state      <= ONE;
                        can_accept <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    can_accept <= 1'b1;
                    has_data   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic.  Four instances run side by side:
//   0: DW=32, clearing flush   (directed: reset, streaming, skid, flush in FULL)
//   1: DW=32, holding flush    (directed: flush keeps out_data)
//   2: DW=97, clearing flush   (random soak)
//   3: DW=1,  holding flush    (random soak)
// A FIFO-list model per instance predicts count/valid/ready/data and is
// compared on every falling edge once reset has been applied.
module tb_pipe_stage_elastic;

    logic clk;
    logic rst;
    logic compareOn;

    int checkCount;
    int passCount;

    logic        drvValid [4];
    logic        drvReady [4];
    logic        drvFlush [4];
    logic [96:0] drvData  [4];

    logic [96:0] dutData  [4];
    logic        dutValid [4];
    logic        dutReady [4];
    logic [1:0]  dutCount [4];

    int          mCnt   [4];
    logic [96:0] mHead  [4];
    logic [96:0] mNext  [4];
    logic [96:0] mShown [4];

    pipe_stage_elastic_if #(.DW(32)) busA ();
    pipe_stage_elastic_if #(.DW(32)) busB ();
    pipe_stage_elastic_if #(.DW(97)) busC ();
    pipe_stage_elastic_if #(.DW(1))  busD ();

    pipe_stage_elastic #(.DW(32), .CLR_ON_FLUSH(1'b1)) dutA (.clk(clk), .rst(rst), .bus(busA));
    pipe_stage_elastic #(.DW(32), .CLR_ON_FLUSH(1'b0)) dutB (.clk(clk), .rst(rst), .bus(busB));
    pipe_stage_elastic #(.DW(97), .CLR_ON_FLUSH(1'b1)) dutC (.clk(clk), .rst(rst), .bus(busC));
    pipe_stage_elastic #(.DW(1),  .CLR_ON_FLUSH(1'b0)) dutD (.clk(clk), .rst(rst), .bus(busD));

    assign busA.in_valid  = drvValid[0];
    assign busA.out_ready = drvReady[0];
    assign busA.flush     = drvFlush[0];
    assign busA.in_data   = drvData[0][31:0];
    assign busB.in_valid  = drvValid[1];
    assign busB.out_ready = drvReady[1];
    assign busB.flush     = drvFlush[1];
    assign busB.in_data   = drvData[1][31:0];
    assign busC.in_valid  = drvValid[2];
    assign busC.out_ready = drvReady[2];
    assign busC.flush     = drvFlush[2];
    assign busC.in_data   = drvData[2];
    assign busD.in_valid  = drvValid[3];
    assign busD.out_ready = drvReady[3];
    assign busD.flush     = drvFlush[3];
    assign busD.in_data   = drvData[3][0:0];

    assign dutData[0]  = {65'd0, busA.out_data};
    assign dutData[1]  = {65'd0, busB.out_data};
    assign dutData[2]  = busC.out_data;
    assign dutData[3]  = {96'd0, busD.out_data};
    assign dutValid[0] = busA.out_valid;
    assign dutValid[1] = busB.out_valid;
    assign dutValid[2] = busC.out_valid;
    assign dutValid[3] = busD.out_valid;
    assign dutReady[0] = busA.in_ready;
    assign dutReady[1] = busB.in_ready;
    assign dutReady[2] = busC.in_ready;
    assign dutReady[3] = busD.in_ready;
    assign dutCount[0] = busA.count;
    assign dutCount[1] = busB.count;
    assign dutCount[2] = busC.count;
    assign dutCount[3] = busD.count;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [96:0] widthMask(input int idx);
        logic [96:0] one;
        int w;
        one = 97'd1;
        case (idx)
            2:       w = 97;
            3:       w = 1;
            default: w = 32;
        endcase
        return (one << w) - one;
    endfunction

    function automatic bit clearsOnFlush(input int idx);
        return (idx == 0) || (idx == 2);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkState(input int idx, input string tag, input int expCount,
                              input logic expValid, input logic expReady, input logic [96:0] expData);
        checkOutput({tag, " count"}, 128'(dutCount[idx]), 128'(expCount));
        checkOutput({tag, " out_valid"}, 128'(dutValid[idx]), 128'(expValid));
        checkOutput({tag, " in_ready"}, 128'(dutReady[idx]), 128'(expReady));
        checkOutput({tag, " out_data"}, 128'(dutData[idx]), 128'(expData));
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic [96:0] data,
                                 input logic ready, input logic flush);
        drvValid[idx] = valid;
        drvData[idx]  = data;
        drvReady[idx] = ready;
        drvFlush[idx] = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered list of at most two payloads, plus the
    // value last presented on out_data, advanced at every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rst) begin
                    mCnt[i]   = 0;
                    mShown[i] = '0;
                end else if (drvFlush[i]) begin
                    mCnt[i] = 0;
                    if (clearsOnFlush(i)) mShown[i] = '0;
                end else begin
                    bit doPush;
                    bit doPop;
                    doPop  = (mCnt[i] != 0) && drvReady[i];
                    doPush = drvValid[i] && (mCnt[i] < 2);
                    if (doPop) begin
                        mHead[i] = mNext[i];
                        mCnt[i]  = mCnt[i] - 1;
                    end
                    if (doPush) begin
                        if (mCnt[i] == 0) mHead[i] = drvData[i] & widthMask(i);
                        else              mNext[i] = drvData[i] & widthMask(i);
                        mCnt[i] = mCnt[i] + 1;
                    end
                    if (mCnt[i] != 0) mShown[i] = mHead[i];
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (compareOn) begin
                for (int i = 0; i < 4; i++) begin
                    checkOutput($sformatf("model%0d", i),
                                128'({dutCount[i], dutValid[i], dutReady[i], dutData[i]}),
                                128'({2'(mCnt[i]), mCnt[i] != 0, mCnt[i] != 2, mShown[i]}));
                end
            end
        end
    end

    // Instance 0: streaming, skid and clearing flush in FULL.
    task automatic runDirectedA();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1'b1, 97'(k), 1'b1, 1'b0);
            tick();
            checkState(0, $sformatf("stream%0d", k), 1, 1'b1, 1'b1, 97'(k));
        end
        applyStimulus(0, 1'b0, 97'h0, 1'b1, 1'b0);
        tick();
        checkState(0, "streamDrain", 0, 1'b0, 1'b1, 97'h8);

        applyStimulus(0, 1'b1, 97'hA, 1'b1, 1'b0);
        tick();
        checkState(0, "skidA", 1, 1'b1, 1'b1, 97'hA);
        applyStimulus(0, 1'b1, 97'hB, 1'b0, 1'b0);
        tick();
        checkState(0, "skidB", 2, 1'b1, 1'b0, 97'hA);
        applyStimulus(0, 1'b1, 97'hC, 1'b0, 1'b0);
        tick();
        checkState(0, "skidHold1", 2, 1'b1, 1'b0, 97'hA);
        tick();
        checkState(0, "skidHold2", 2, 1'b1, 1'b0, 97'hA);
        applyStimulus(0, 1'b1, 97'hC, 1'b1, 1'b0);
        tick();
        checkState(0, "skidPopA", 1, 1'b1, 1'b1, 97'hB);
        tick();
        checkState(0, "skidPopB", 1, 1'b1, 1'b1, 97'hC);
        applyStimulus(0, 1'b0, 97'h0, 1'b1, 1'b0);
        tick();
        checkState(0, "skidPopC", 0, 1'b0, 1'b1, 97'hC);

        applyStimulus(0, 1'b1, 97'h11, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 1'b1, 97'h22, 1'b0, 1'b0);
        tick();
        checkState(0, "preFlush", 2, 1'b1, 1'b0, 97'h11);
        applyStimulus(0, 1'b1, 97'h33, 1'b1, 1'b1);
        tick();
        checkState(0, "flushFull", 0, 1'b0, 1'b1, 97'h0);
        applyStimulus(0, 1'b0, 97'h0, 1'b1, 1'b0);
        tick();
        checkState(0, "flushDropped", 0, 1'b0, 1'b1, 97'h0);
    endtask

    // Instance 1: flush that leaves the data register untouched.
    task automatic runDirectedB();
        applyStimulus(1, 1'b1, 97'h55, 1'b0, 1'b0);
        tick();
        checkState(1, "hold55", 1, 1'b1, 1'b1, 97'h55);
        applyStimulus(1, 1'b0, 97'h0, 1'b0, 1'b1);
        tick();
        checkState(1, "flushKeep", 0, 1'b0, 1'b1, 97'h55);
        applyStimulus(1, 1'b1, 97'h66, 1'b0, 1'b0);
        tick();
        checkState(1, "after66", 1, 1'b1, 1'b1, 97'h66);
        applyStimulus(1, 1'b0, 97'h0, 1'b1, 1'b0);
        tick();
        checkState(1, "drain66", 0, 1'b0, 1'b1, 97'h66);
    endtask

    // Instances 2 and 3: random traffic with sparse flushes.
    task automatic runSoak();
        logic [127:0] r;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 2; i < 4; i++) begin
                r = {$urandom, $urandom, $urandom, $urandom};
                applyStimulus(i, $urandom_range(0, 3) != 0, r[96:0],
                              $urandom_range(0, 1) != 0, $urandom_range(0, 99) == 0);
            end
            tick();
        end
        applyStimulus(2, 1'b0, 97'h0, 1'b1, 1'b0);
        applyStimulus(3, 1'b0, 97'h0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
    endtask

    // Sequencer: reset with in_valid high, then run all scenarios in parallel.
    initial begin
        checkCount = 0;
        passCount  = 0;
        compareOn  = 1'b0;
        rst        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 1'b1, 97'hDEAD, 1'b1, 1'b0);
        end
        tick();
        tick();
        checkState(0, "reset", 0, 1'b0, 1'b1, 97'h0);
        checkState(2, "resetWide", 0, 1'b0, 1'b1, 97'h0);
        compareOn = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i, 1'b0, 97'h0, 1'b0, 1'b0);
        end
        fork
            runDirectedA();
            runDirectedB();
            runSoak();
        join
        tick();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
